// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - memory opcode encodings and arbiter state type
package mem_port_arbiter_pkg;

  localparam int MEM_FCN_BIT_NUM = 1;
  localparam int MEM_TYP_BIT_NUM = 3;

  localparam logic [MEM_FCN_BIT_NUM-1:0] M_XRD = 1'b0;
  localparam logic [MEM_FCN_BIT_NUM-1:0] M_XWR = 1'b1;

  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_X  = 3'd0;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_B  = 3'd1;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_H  = 3'd2;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_W  = 3'd3;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_BU = 3'd5;
  localparam logic [MEM_TYP_BIT_NUM-1:0] MT_HU = 3'd6;

  typedef enum logic [1:0] {
    ARB_ST_IDLE    = 2'd0,
    ARB_ST_DM_BUSY = 2'd1,
    ARB_ST_IF_BUSY = 2'd2
  } arb_state_e;

  // Counter holds MEM_LAT-1, so two bits cover the whole 1..4 latency range.
  localparam int CNT_W = 2;

  function automatic logic is_misaligned(input logic [MEM_TYP_BIT_NUM-1:0] typ,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (typ == MT_H || typ == MT_HU) mis = off[0];
    else if (typ == MT_W)            mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store byte-lane steering and load extract/extend
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [MEM_TYP_BIT_NUM-1:0] st_typ,
  input  logic [1:0]                 st_off,
  input  logic [31:0]                st_data,
  output logic [3:0]                 st_be,
  output logic [31:0]                st_lanes,
  input  logic [MEM_TYP_BIT_NUM-1:0] ld_typ,
  input  logic [1:0]                 ld_off,
  input  logic [31:0]                ld_raw,
  output logic [31:0]                ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    st_be    = 4'b0000;
    st_lanes = st_data;
    case (st_typ)
      MT_B, MT_BU: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      MT_H, MT_HU: begin
        st_be    = 4'b0011 << st_off;
        st_lanes = {2{st_data[15:0]}};
      end
      MT_W:    st_be = 4'hF;
      default: st_be = 4'b0000;
    endcase
  end

  assign ld_byte = ld_raw[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_raw[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = ld_raw;
    case (ld_typ)
      MT_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      MT_BU:   ld_data = {24'h0, ld_byte};
      MT_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      MT_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port synchronous RAM
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_req,
  input  logic [AW-1:0]              if_addr,
  output logic                       if_rvalid,
  output logic [31:0]                if_rdata,
  output logic                       if_stall,
  input  logic                       dm_req,
  input  logic [MEM_FCN_BIT_NUM-1:0] dm_fcn,
  input  logic [MEM_TYP_BIT_NUM-1:0] dm_typ,
  input  logic [AW-1:0]              dm_addr,
  input  logic [31:0]                dm_wdata,
  output logic                       dm_rvalid,
  output logic [31:0]                dm_rdata,
  output logic                       dm_misalign,
  output logic                       full_stall,
  output logic                       mem_en,
  output logic [3:0]                 mem_we,
  output logic [AW-3:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  arb_state_e                 state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [MEM_TYP_BIT_NUM-1:0] op_typ;
  logic [1:0]                 op_off;
  logic                       op_load;
  logic                       op_mis;
  logic [31:0]                dm_rdata_q;
  logic [31:0]                if_rdata_q;
  logic                       dm_mis_now;
  logic                       dm_issue;
  logic                       if_issue;
  logic                       done;
  logic [3:0]                 st_be;
  logic [31:0]                st_lanes;
  logic [31:0]                ld_data;
  logic                       unused_if_addr_lsbs;

  assign unused_if_addr_lsbs = ^if_addr[1:0];

  assign dm_mis_now = is_misaligned(dm_typ, dm_addr[1:0]);
  // Qualified by ~rst so nothing is issued or answered in a reset cycle.
  assign dm_issue = !rst && (state == ARB_ST_IDLE) && dm_req;
  assign if_issue = !rst && (state == ARB_ST_IDLE) && !dm_req && if_req;
  assign done     = !rst && (state != ARB_ST_IDLE) && (cnt == '0);

  mem_lane_align u_align (
    .st_typ   (dm_typ),
    .st_off   (dm_addr[1:0]),
    .st_data  (dm_wdata),
    .st_be    (st_be),
    .st_lanes (st_lanes),
    .ld_typ   (op_typ),
    .ld_off   (op_off),
    .ld_raw   (mem_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_ST_IDLE;
      cnt        <= '0;
      op_typ     <= MT_X;
      op_off     <= 2'b00;
      op_load    <= 1'b0;
      op_mis     <= 1'b0;
      dm_rdata_q <= 32'h0;
      if_rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (dm_issue) begin
        op_typ  <= dm_typ;
        op_off  <= dm_addr[1:0];
        op_load <= (dm_fcn == M_XRD);
        op_mis  <= dm_mis_now;
      end
      if (dm_rvalid) dm_rdata_q <= dm_rdata;
      if (if_rvalid) if_rdata_q <= if_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ARB_ST_IDLE: begin
        if (dm_req) begin
          state_nxt = ARB_ST_DM_BUSY;
          cnt_nxt   = dm_mis_now ? '0 : LAT_M1;
        end else if (if_req) begin
          state_nxt = ARB_ST_IF_BUSY;
          cnt_nxt   = LAT_M1;
        end
      end
      ARB_ST_DM_BUSY, ARB_ST_IF_BUSY: begin
        if (cnt == '0) state_nxt = ARB_ST_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = ARB_ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = 32'h0;
    dm_rvalid   = 1'b0;
    dm_misalign = 1'b0;
    dm_rdata    = dm_rdata_q;
    if_rvalid   = 1'b0;
    if_rdata    = if_rdata_q;

    if (dm_issue && !dm_mis_now) begin
      mem_en   = 1'b1;
      mem_addr = dm_addr[AW-1:2];
      if (dm_fcn == M_XWR) begin
        mem_we    = st_be;
        mem_wdata = st_lanes;
      end
    end
    if (if_issue) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[AW-1:2];
    end

    if (done && state == ARB_ST_DM_BUSY) begin
      dm_rvalid   = 1'b1;
      dm_misalign = op_mis;
      if (op_mis)       dm_rdata = 32'h0;
      else if (op_load) dm_rdata = ld_data;
    end
    // A killed fetch still drains its RAM slot but is not reported.
    if (done && state == ARB_ST_IF_BUSY && if_req) begin
      if_rvalid = 1'b1;
      if_rdata  = mem_rdata;
    end
  end

  assign full_stall = dm_req & ~dm_rvalid;
  assign if_stall   = if_req & ~if_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized checks of mem_port_arbiter against a byte-level memory model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LAT = 2;
  localparam int AW  = 32;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       if_req;
  logic [AW-1:0]              if_addr;
  logic                       if_rvalid;
  logic [31:0]                if_rdata;
  logic                       if_stall;
  logic                       dm_req;
  logic [MEM_FCN_BIT_NUM-1:0] dm_fcn;
  logic [MEM_TYP_BIT_NUM-1:0] dm_typ;
  logic [AW-1:0]              dm_addr;
  logic [31:0]                dm_wdata;
  logic                       dm_rvalid;
  logic [31:0]                dm_rdata;
  logic                       dm_misalign;
  logic                       full_stall;
  logic                       mem_en;
  logic [3:0]                 mem_we;
  logic [AW-3:0]              mem_addr;
  logic [31:0]                mem_wdata;
  logic [31:0]                mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LAT(LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_fcn(dm_fcn), .dm_typ(dm_typ), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_misalign(dm_misalign), .full_stall(full_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical RAM: 64 words, read data appears LAT cycles after mem_en.
  logic        ram_init;
  logic [31:0] ram   [0:63];
  logic [31:0] rpipe [0:LAT-1];
  logic [7:0]  ref_mem [0:255];

  function automatic logic [31:0] init_word(input int w);
    return 32'h9E3779B9 * 32'(w + 1);
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int w = 0; w < 64; w++) ram[w] <= init_word(w);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      rpipe[0] <= ram[mem_addr[5:0]];
    end
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  function automatic logic ref_mis(input logic [2:0] typ, input logic [31:0] addr);
    int o;
    o = int'(addr[1:0]);
    if (typ == MT_H || typ == MT_HU) return (o % 2) != 0;
    if (typ == MT_W) return o != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] typ, input logic [31:0] addr);
    int a, v;
    a = int'(addr[7:0]);
    v = 0;
    case (typ)
      MT_B:  begin v = int'(ref_mem[a]); if (v >= 128) v -= 256; end
      MT_BU: v = int'(ref_mem[a]);
      MT_H:  begin v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]); if (v >= 32768) v -= 65536; end
      MT_HU: v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]);
      default: begin
        a = a - (a % 4);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      end
    endcase
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data);
    int a, n;
    a = int'(addr[7:0]);
    n = (typ == MT_B) ? 1 : (typ == MT_H) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[a+i] = data[8*i +: 8];
  endtask

  function automatic logic [3:0] exp_we(input logic [2:0] typ, input logic [31:0] addr);
    int o;
    o = int'(addr[1:0]);
    if (typ == MT_B) return 4'(1 << o);
    if (typ == MT_H) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] typ, input logic [31:0] data);
    if (typ == MT_B) return 32'(data[7:0]) * 32'h01010101;
    if (typ == MT_H) return 32'(data[15:0]) * 32'h00010001;
    return data;
  endfunction

  // One data access from IDLE; reports what the DUT did on the issue cycle and at completion.
  task automatic dm_op(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                       output logic mis, output logic en0, output logic [3:0] we0,
                       output logic [29:0] addr0, output logic [31:0] wd0, output int stall);
    @(negedge clk);
    dm_req = 1'b1; dm_fcn = fcn; dm_typ = typ; dm_addr = addr; dm_wdata = wdata;
    #1;
    en0 = mem_en; we0 = mem_we; addr0 = mem_addr; wd0 = mem_wdata;
    lat = -1; rd = 32'h0; mis = 1'b0; stall = 0;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) begin @(negedge clk); #1; end
      if (full_stall) stall++;
      if (dm_rvalid) begin lat = n; rd = dm_rdata; mis = dm_misalign; break; end
    end
    @(negedge clk);
    dm_req = 1'b0; dm_fcn = M_XRD; dm_typ = MT_X; dm_addr = '0; dm_wdata = '0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL dm_timeout: no dm_rvalid within 16 cycles, addr %h", addr);
    end
  endtask

  task automatic if_op(input logic [31:0] addr, output int lat, output logic [31:0] rd,
                       output logic en0, output logic [29:0] addr0);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    #1;
    en0 = mem_en; addr0 = mem_addr; lat = -1; rd = 32'h0;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) begin @(negedge clk); #1; end
      if (if_rvalid) begin lat = n; rd = if_rdata; break; end
    end
    @(negedge clk);
    if_req = 1'b0; if_addr = '0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL if_timeout: no if_rvalid within 16 cycles, addr %h", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_init = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_fcn = M_XRD; dm_typ = MT_X; dm_addr = '0; dm_wdata = '0;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a / 4)[8*(a % 4) +: 8];
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    dm_req = 1'b1; if_req = 1'b1; #1;
    checks++;
    if ({full_stall, if_stall, mem_en} !== 3'b110) begin
      errors++; $display("FAIL reset_stall_eq: {full_stall,if_stall,mem_en}=%b want 110", {full_stall, if_stall, mem_en});
    end
    dm_req = 1'b0; if_req = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, dm_rvalid, dm_misalign, dm_rdata,
         if_rvalid, if_rdata, full_stall, if_stall} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero, mem_en=%b dm_rdata=%h if_rdata=%h", mem_en, dm_rdata, if_rdata);
    end
  endtask

  task automatic test_store_word();
    int lat, stall; logic [31:0] rd, wd0; logic mis, en0; logic [3:0] we0; logic [29:0] a0;
    dm_op(M_XWR, MT_W, 32'h100, 32'hDEADBEEF, lat, rd, mis, en0, we0, a0, wd0, stall);
    ref_store(MT_W, 32'h100, 32'hDEADBEEF);
    checks++;
    if ({en0, we0, a0, wd0} !== {1'b1, 4'hF, 30'h40, 32'hDEADBEEF}) begin
      errors++; $display("FAIL sw_issue: en=%b we=%h addr=%h wdata=%h want 1 f 40 deadbeef", en0, we0, a0, wd0);
    end
    checks++;
    if (lat !== LAT || stall !== LAT || mis !== 1'b0) begin
      errors++; $display("FAIL sw_timing: lat=%0d stall=%0d mis=%b want %0d %0d 0", lat, stall, mis, LAT, LAT);
    end
    dm_op(M_XRD, MT_W, 32'h100, 32'h0, lat, rd, mis, en0, we0, a0, wd0, stall);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_after_sw: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_byte_lanes();
    int lat, stall; logic [31:0] rd, wd0; logic mis, en0; logic [3:0] we0; logic [29:0] a0;
    dm_op(M_XWR, MT_B, 32'h103, 32'h0000005A, lat, rd, mis, en0, we0, a0, wd0, stall);
    ref_store(MT_B, 32'h103, 32'h5A);
    checks++;
    if (we0 !== 4'b1000 || wd0 !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL sb_lanes: we=%b wdata=%h want 1000 5a5a5a5a", we0, wd0);
    end
    dm_op(M_XRD, MT_B, 32'h103, 32'h0, lat, rd, mis, en0, we0, a0, wd0, stall);
    checks++;
    if (rd !== 32'h0000005A) begin
      errors++; $display("FAIL lb_pos: got %h want 0000005a", rd);
    end
    dm_op(M_XWR, MT_B, 32'h102, 32'hFFFFFF80, lat, rd, mis, en0, we0, a0, wd0, stall);
    ref_store(MT_B, 32'h102, 32'h80);
    dm_op(M_XRD, MT_B, 32'h102, 32'h0, lat, rd, mis, en0, we0, a0, wd0, stall);
    checks++;
    if (rd !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_neg: got %h want ffffff80", rd);
    end
    dm_op(M_XRD, MT_BU, 32'h102, 32'h0, lat, rd, mis, en0, we0, a0, wd0, stall);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++; $display("FAIL lbu: got %h want 00000080", rd);
    end
  endtask

  task automatic test_misalign();
    int lat, stall; logic [31:0] rd, wd0; logic mis, en0; logic [3:0] we0; logic [29:0] a0;
    dm_op(M_XRD, MT_H, 32'h101, 32'h0, lat, rd, mis, en0, we0, a0, wd0, stall);
    checks++;
    if ({en0, mis, rd} !== {1'b0, 1'b1, 32'h0} || lat !== 1) begin
      errors++; $display("FAIL lh_misalign: en=%b mis=%b rd=%h lat=%0d want 0 1 0 1", en0, mis, rd, lat);
    end
    dm_op(M_XWR, MT_W, 32'h106, 32'h12345678, lat, rd, mis, en0, we0, a0, wd0, stall);
    checks++;
    if ({en0, we0, mis} !== {1'b0, 4'h0, 1'b1} || lat !== 1) begin
      errors++; $display("FAIL sw_misalign: en=%b we=%h mis=%b lat=%0d want 0 0 1 1", en0, we0, mis, lat);
    end
  endtask

  task automatic test_contention();
    int t_if_issue, t_if_rv, t_dm_rv; logic [31:0] dm_rd, if_rd; logic extra_en;
    t_if_issue = -1; t_if_rv = -1; t_dm_rv = -1; extra_en = 1'b0; dm_rd = '0; if_rd = '0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_fcn = M_XRD; dm_typ = MT_W; dm_addr = 32'h108;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, if_stall} !== {1'b1, 4'h0, 30'h42, 1'b1}) begin
      errors++; $display("FAIL contend_dm_first: en=%b we=%h addr=%h if_stall=%b want 1 0 42 1", mem_en, mem_we, mem_addr, if_stall);
    end
    for (int n = 1; n < 20; n++) begin
      @(negedge clk);
      if (t_dm_rv >= 0) begin dm_req = 1'b0; dm_typ = MT_X; dm_addr = '0; end
      if (t_if_rv >= 0) begin if_req = 1'b0; if_addr = '0; end
      #1;
      if (mem_en && mem_addr == 30'h41 && t_if_issue < 0) t_if_issue = n;
      else if (mem_en) extra_en = 1'b1;
      if (dm_rvalid) begin t_dm_rv = n; dm_rd = dm_rdata; end
      if (if_rvalid) begin t_if_rv = n; if_rd = if_rdata; end
      if (t_if_rv >= 0 && !if_req) break;
    end
    if_req = 1'b0; dm_req = 1'b0;
    checks++;
    if (t_dm_rv !== LAT || dm_rd !== ref_load(MT_W, 32'h108)) begin
      errors++; $display("FAIL contend_dm_done: t=%0d rd=%h want %0d %h", t_dm_rv, dm_rd, LAT, ref_load(MT_W, 32'h108));
    end
    checks++;
    if (t_if_issue !== LAT + 1 || t_if_rv !== 2 * LAT + 1 || extra_en !== 1'b0) begin
      errors++; $display("FAIL contend_if_timing: issue=%0d rvalid=%0d extra_en=%b want %0d %0d 0", t_if_issue, t_if_rv, extra_en, LAT + 1, 2 * LAT + 1);
    end
    checks++;
    if (if_rd !== ref_load(MT_W, 32'h104)) begin
      errors++; $display("FAIL contend_if_data: got %h want %h", if_rd, ref_load(MT_W, 32'h104));
    end
  endtask

  task automatic test_reset_busy();
    logic saw_dm_rv; int t_if_rv; logic [31:0] if_rd;
    saw_dm_rv = 1'b0; t_if_rv = -1; if_rd = '0;
    @(negedge clk);
    dm_req = 1'b1; dm_fcn = M_XRD; dm_typ = MT_W; dm_addr = 32'h10C;
    #1; saw_dm_rv = dm_rvalid;
    @(negedge clk);
    rst = 1'b1; dm_req = 1'b0; dm_typ = MT_X; dm_addr = '0; if_req = 1'b1; if_addr = 32'h110;
    #1;
    saw_dm_rv = saw_dm_rv | dm_rvalid;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++; $display("FAIL rst_busy_en: mem_en=%b during reset want 0", mem_en);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 30'h44}) begin
      errors++; $display("FAIL rst_busy_fetch: en=%b addr=%h want 1 44", mem_en, mem_addr);
    end
    for (int n = 1; n < 16; n++) begin
      @(negedge clk); #1;
      saw_dm_rv = saw_dm_rv | dm_rvalid;
      if (if_rvalid) begin t_if_rv = n; if_rd = if_rdata; break; end
    end
    @(negedge clk); if_req = 1'b0; if_addr = '0;
    checks++;
    if (saw_dm_rv !== 1'b0 || t_if_rv !== LAT || if_rd !== ref_load(MT_W, 32'h110)) begin
      errors++; $display("FAIL rst_busy_after: dm_rv=%b if_t=%0d if_rd=%h want 0 %0d %h", saw_dm_rv, t_if_rv, if_rd, LAT, ref_load(MT_W, 32'h110));
    end
  endtask

  task automatic test_fetch_kill();
    logic saw_if_rv, early_en; int t_dm_issue, t_dm_rv, stall; logic [31:0] dm_rd;
    saw_if_rv = 1'b0; early_en = 1'b0; t_dm_issue = -1; t_dm_rv = -1; stall = 0; dm_rd = '0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h114;
    #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 30'h45}) begin
      errors++; $display("FAIL kill_issue: en=%b addr=%h want 1 45", mem_en, mem_addr);
    end
    for (int n = 1; n < 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b1; dm_fcn = M_XRD; dm_typ = MT_HU; dm_addr = 32'h11A;
      end
      if (t_dm_rv >= 0) begin dm_req = 1'b0; dm_typ = MT_X; dm_addr = '0; break; end
      #1;
      saw_if_rv = saw_if_rv | if_rvalid;
      if (full_stall) stall++;
      if (mem_en && t_dm_issue < 0) begin
        if (mem_addr == 30'h46) t_dm_issue = n; else early_en = 1'b1;
      end
      if (dm_rvalid) begin t_dm_rv = n; dm_rd = dm_rdata; end
    end
    checks++;
    if (saw_if_rv !== 1'b0 || early_en !== 1'b0 || t_dm_issue !== LAT + 1) begin
      errors++; $display("FAIL kill_timing: if_rv=%b early_en=%b dm_issue=%0d want 0 0 %0d", saw_if_rv, early_en, t_dm_issue, LAT + 1);
    end
    checks++;
    if (t_dm_rv !== 2 * LAT + 1 || stall !== 2 * LAT || dm_rd !== ref_load(MT_HU, 32'h11A)) begin
      errors++; $display("FAIL kill_dm: t=%0d stall=%0d rd=%h want %0d %0d %h", t_dm_rv, stall, dm_rd, 2 * LAT + 1, 2 * LAT, ref_load(MT_HU, 32'h11A));
    end
  endtask

  task automatic test_random();
    logic [2:0] ltyps [5] = '{MT_B, MT_H, MT_W, MT_BU, MT_HU};
    logic [2:0] styps [3] = '{MT_B, MT_H, MT_W};
    int lat, stall, kind; logic [31:0] rd, wd0, addr, data, exp; logic mis, en0, emis;
    logic [3:0] we0; logic [29:0] a0; logic [2:0] typ;
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 2);
      addr = 32'h100 + 32'($urandom_range(0, 255));
      data = $urandom;
      if (kind == 2) begin
        addr = addr & ~32'h3;
        if_op(addr, lat, rd, en0, a0);
        exp = ref_load(MT_W, addr);
        checks++;
        if (lat !== LAT || rd !== exp || en0 !== 1'b1 || a0 !== addr[31:2]) begin
          errors++; $display("FAIL rnd_fetch[%0d]: addr=%h lat=%0d rd=%h en=%b want %0d %h 1", it, addr, lat, rd, en0, LAT, exp);
        end
      end else if (kind == 1) begin
        typ = styps[$urandom_range(0, 2)];
        emis = ref_mis(typ, addr);
        dm_op(M_XWR, typ, addr, data, lat, rd, mis, en0, we0, a0, wd0, stall);
        checks++;
        if (mis !== emis || en0 !== !emis || lat !== (emis ? 1 : LAT) ||
            (!emis && (we0 !== exp_we(typ, addr) || wd0 !== exp_wdata(typ, data) || a0 !== addr[31:2]))) begin
          errors++; $display("FAIL rnd_store[%0d]: typ=%0d addr=%h mis=%b en=%b we=%h wd=%h lat=%0d want mis=%b we=%h wd=%h", it, typ, addr, mis, en0, we0, wd0, lat, emis, exp_we(typ, addr), exp_wdata(typ, data));
        end
        if (!emis) ref_store(typ, addr, data);
      end else begin
        typ = ltyps[$urandom_range(0, 4)];
        emis = ref_mis(typ, addr);
        exp = emis ? 32'h0 : ref_load(typ, addr);
        dm_op(M_XRD, typ, addr, 32'h0, lat, rd, mis, en0, we0, a0, wd0, stall);
        checks++;
        if (mis !== emis || rd !== exp || en0 !== !emis || we0 !== 4'h0 || lat !== (emis ? 1 : LAT)) begin
          errors++; $display("FAIL rnd_load[%0d]: typ=%0d addr=%h mis=%b rd=%h en=%b lat=%0d want mis=%b rd=%h", it, typ, addr, mis, rd, en0, lat, emis, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte_lanes();
    test_misalign();
    test_contention();
    test_reset_busy();
    test_fetch_kill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
